// File: rtl/rijndael_pkg.sv
// Shared types, constants and helpers for the AES key-expansion slice.
package rijndael_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } kx_state_t;

  localparam logic [7:0] RC_INIT = 8'h01;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr(input int nk);
    return nk + 6;
  endfunction

  function automatic int total_words(input int nk);
    return 4 * (nr(nk) + 1);
  endfunction

  // Number of NK-word schedule steps needed to cover every emitted word.
  function automatic int nsteps(input int nk);
    return (total_words(nk) - nk + nk - 1) / nk;
  endfunction

endpackage

// File: rtl/rijndael_keyschedulestep.sv
// One combinational key-schedule step: NK old words in, NK new words out.
// Word i lives at [32i+31:32i]; bytes are most-significant first.
module rijndael_keyschedulestep
  import rijndael_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic [32*NK-1:0] keystate,
  input  logic [7:0]       rc,
  output logic [32*NK-1:0] next_keystate
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  word_t last_word;
  word_t prev;

  // Chain each new word off the previous new word; NK=8 adds SubWord at word 4.
  always_comb begin
    next_keystate = '0;
    last_word     = keystate[32*(NK-1) +: 32];
    prev          = sub_word({last_word[23:0], last_word[31:24]}) ^ {rc, 24'h000000};
    for (int i = 0; i < NK; i++) begin
      if (NK > 6 && i == 4) prev = sub_word(prev);
      prev = keystate[32*i +: 32] ^ prev;
      next_keystate[32*i +: 32] = prev;
    end
  end

endmodule

// File: rtl/rijndael_keyexpansion.sv
// Sequential AES key expansion: iterates the schedule step, buffers words
// and streams NR+1 round keys in order.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; valid never waits on ready, and a producer holding valid keeps
// its data stable until the transfer.
module rijndael_keyexpansion
  import rijndael_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [32*NK-1:0] key,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [127:0]     rk,
  output logic [3:0]       rk_index,
  output logic             rk_last,
  output logic             rk_valid,
  input  logic             rk_ready,
  output logic             busy
);

  localparam int NR          = nr(NK);
  localparam int TOTAL_WORDS = total_words(NK);
  localparam int NSTEPS      = nsteps(NK);
  localparam int BUF_WORDS   = 12;

  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("rijndael_keyexpansion: NK must be 4, 6 or 8");
  end
  if (NK * (NSTEPS + 1) < TOTAL_WORDS) begin : g_bad_steps
    $error("rijndael_keyexpansion: step count does not cover the schedule");
  end

  kx_state_t        state, state_next;
  word_t            buf_q    [BUF_WORDS];
  word_t            buf_next [BUF_WORDS];
  logic [3:0]       count, count_next;
  logic [3:0]       step_cnt;
  logic [7:0]       rc;
  logic [32*NK-1:0] keystate, next_keystate;
  logic             load, pop, push, done;
  int               base;

  rijndael_keyschedulestep #(.NK(NK)) u_step (
    .keystate      (keystate),
    .rc            (rc),
    .next_keystate (next_keystate)
  );

  assign rk = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    busy       = 1'b0;
    rk_valid   = 1'b0;
    rk_last    = 1'b0;
    load       = 1'b0;
    pop        = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        rk_valid = (count >= 4'd4);
        rk_last  = rk_valid && (rk_index == 4'(NR));
        pop      = rk_valid && rk_ready;
        if (pop && rk_last) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Push when steps remain and the words fit after any same-cycle pop.
  always_comb begin
    push = (state == RUN) && !done && (step_cnt < 4'(NSTEPS)) &&
           (int'(count) + NK <= BUF_WORDS + (pop ? 4 : 0));
  end

  // Buffer compaction: drop the 4 oldest on pop, append new words after the survivors.
  always_comb begin
    buf_next   = buf_q;
    count_next = count;
    base       = int'(count);
    if (load) begin
      for (int i = 0; i < BUF_WORDS; i++) buf_next[i] = '0;
      for (int i = 0; i < NK; i++) buf_next[i] = key[32*i +: 32];
      count_next = 4'(NK);
    end else if (done) begin
      count_next = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < BUF_WORDS - 4; i++) buf_next[i] = buf_q[i+4];
        for (int i = BUF_WORDS - 4; i < BUF_WORDS; i++) buf_next[i] = '0;
        base = base - 4;
      end
      if (push) begin
        for (int i = 0; i < BUF_WORDS; i++) begin
          for (int j = 0; j < NK; j++) begin
            if (i == base + j) buf_next[i] = next_keystate[32*j +: 32];
          end
        end
      end
      count_next = 4'(base + (push ? NK : 0));
    end
  end

  // Control counters, round constant and round index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      step_cnt <= '0;
      rk_index <= '0;
      rc       <= RC_INIT;
    end else begin
      count <= count_next;
      if (load) begin
        step_cnt <= '0;
        rk_index <= '0;
        rc       <= RC_INIT;
      end else begin
        if (push) begin
          step_cnt <= step_cnt + 4'd1;
          rc       <= xtime(rc);
        end
        if (done)     rk_index <= '0;
        else if (pop) rk_index <= rk_index + 4'd1;
      end
    end
  end

  // Data storage needs no reset: count and state gate its visibility.
  always_ff @(posedge clk) begin
    buf_q <= buf_next;
    if (load)      keystate <= key;
    else if (push) keystate <= next_keystate;
  end

endmodule

// File: tb/tb_rijndael_keyexpansion.sv
// Bench for rijndael_keyexpansion: one instance per key size, FIPS-197
// vectors plus random keys with random backpressure, reset and key-hold cases.
module tb_rijndael_keyexpansion;

  logic         clk;
  logic         rst_n;
  logic [255:0] key_v       [3];
  logic         key_valid_v [3];
  logic         key_ready_v [3];
  logic [127:0] rk_v        [3];
  logic [3:0]   rk_index_v  [3];
  logic         rk_last_v   [3];
  logic         rk_valid_v  [3];
  logic         rk_ready_v  [3];
  logic         busy_v      [3];

  int           n_checks;
  int           n_fail;
  logic [7:0]   sbox_t [256];
  logic [127:0] exp_q [$];
  logic [127:0] first_rk;
  logic [127:0] last_rk;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rijndael_keyexpansion #(.NK(4 + 2*g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key       (key_v[g][32*(4+2*g)-1:0]),
      .key_valid (key_valid_v[g]),
      .key_ready (key_ready_v[g]),
      .rk        (rk_v[g]),
      .rk_index  (rk_index_v[g]),
      .rk_last   (rk_last_v[g]),
      .rk_valid  (rk_valid_v[g]),
      .rk_ready  (rk_ready_v[g]),
      .busy      (busy_v[g])
    );
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box table from the generator walk over GF(2^8) (p steps by 3, q by 1/3).
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [31:0] ref_subword(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  // Textbook expansion, then queue the expected round keys.
  task automatic build_ref(input int nk, input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    int          rcon;
    int          total;
    total = 4 * (nk + 7);
    rcon  = 1;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = k[32*i +: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = ref_subword({t[23:0], t[31:24]}) ^ {rcon[7:0], 24'h000000};
        rcon = rcon * 2;
        if (rcon > 255) rcon = rcon ^ 'h11b;
      end else if (nk > 6 && i % nk == 4) begin
        t = ref_subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    exp_q.delete();
    for (int r = 0; r < nk + 7; r++) exp_q.push_back({w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]});
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom;
    return k;
  endfunction

  // ---------------- drivers ----------------
  // Offers a key and returns at the negedge following the accepting edge.
  task automatic start_key(input int u, input logic [255:0] k);
    int waited;
    @(negedge clk);
    key_v[u]       = k;
    key_valid_v[u] = 1'b1;
    waited = 0;
    while (!key_ready_v[u] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("key_ready_accept", key_ready_v[u], 1);
    @(negedge clk);
    key_valid_v[u] = 1'b0;
  endtask

  // Consumes round keys with pct% ready and scores them against the model.
  task automatic collect(input int u, input logic [255:0] k, input int pct, input bit hold,
                         input logic [255:0] knext, input int stop_after);
    int           nk, nrr, lim, popped, cycles;
    bit           rdy, stalled;
    logic [127:0] held_rk, want;
    logic [3:0]   held_idx;
    nk       = 4 + 2*u;
    nrr      = nk + 6;
    lim      = (stop_after > 0) ? stop_after : nrr + 1;
    popped   = 0;
    cycles   = 0;
    stalled  = 1'b0;
    held_rk  = '0;
    held_idx = '0;
    build_ref(nk, k);
    if (hold) begin
      key_v[u]       = knext;
      key_valid_v[u] = 1'b1;
    end
    check("latency_valid", rk_valid_v[u], 1);
    check("latency_index", rk_index_v[u], 0);
    while (popped < lim && cycles < 400) begin
      rdy = ($urandom_range(99) < pct);
      rk_ready_v[u] = rdy;
      check("busy_run", busy_v[u], 1);
      check("key_ready_run", key_ready_v[u], 0);
      if (stalled) begin
        check("stall_valid", rk_valid_v[u], 1);
        check("stall_rk", rk_v[u], held_rk);
        check("stall_index", rk_index_v[u], held_idx);
      end
      if (rk_valid_v[u] && rdy) begin
        want = exp_q.pop_front();
        check("rk", rk_v[u], want);
        check("rk_index", rk_index_v[u], popped);
        check("rk_last", rk_last_v[u], popped == nrr);
        if (popped == 0) first_rk = rk_v[u];
        last_rk = rk_v[u];
        popped++;
      end
      stalled  = rk_valid_v[u] && !rdy;
      held_rk  = rk_v[u];
      held_idx = rk_index_v[u];
      @(negedge clk);
      cycles++;
    end
    rk_ready_v[u] = 1'b0;
    check("pops_done", popped, lim);
    if (stop_after <= 0) begin
      check("end_key_ready", key_ready_v[u], 1);
      check("end_rk_valid", rk_valid_v[u], 0);
      check("end_busy", busy_v[u], 0);
      if (pct == 100) check("throughput_cycles", cycles, nrr + 1);
    end
    exp_q.delete();
    if (hold) begin
      @(negedge clk);
      key_valid_v[u] = 1'b0;
    end
  endtask

  task automatic check_idle(input int u, input string tag);
    check({tag, "_key_ready"}, key_ready_v[u], 1);
    check({tag, "_rk_valid"}, rk_valid_v[u], 0);
    check({tag, "_busy"}, busy_v[u], 0);
    check({tag, "_rk_last"}, rk_last_v[u], 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [255:0] k, k2;
    n_checks = 0;
    n_fail   = 0;
    first_rk = '0;
    last_rk  = '0;
    build_sbox();
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      key_v[u]       = '0;
      key_valid_v[u] = 1'b0;
      rk_ready_v[u]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 3; u++) check_idle(u, "reset");

    // AES-128 known answer; rk_ready already high while idle.
    rk_ready_v[0] = 1'b1;
    repeat (2) @(negedge clk);
    k = {128'h0, 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516};
    start_key(0, k);
    collect(0, k, 100, 1'b0, '0, 0);
    check("kat128_first", first_rk, 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516);
    check("kat128_last", last_rk, 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8);

    // AES-192 known answer.
    k = {64'h0, 192'h522c6b7b_62f8ead2_809079e5_c810f32b_da0e6452_8e73b0f7};
    start_key(1, k);
    collect(1, k, 100, 1'b0, '0, 0);
    check("kat192_last", last_rk, 128'h01002202_8ecc7204_448c773c_e98ba06f);

    // AES-256 known answer.
    k = 256'h0914dff4_2d9810a3_3b6108d7_1f352c07_857d7781_2b73aef0_15ca71be_603deb10;
    start_key(2, k);
    collect(2, k, 100, 1'b0, '0, 0);
    check("kat256_last", last_rk, 128'h706c631e_046df344_e6188d0b_fe4890d1);

    // Random keys under heavy backpressure, every key size.
    for (int u = 0; u < 3; u++) begin
      for (int n = 0; n < 2; n++) begin
        k = rand_key();
        start_key(u, k);
        collect(u, k, 30, 1'b0, '0, 0);
      end
    end

    // Reset mid-expansion after round key 3 has been taken.
    k = rand_key();
    start_key(1, k);
    collect(1, k, 100, 1'b0, '0, 4);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(1, "midreset");
    k = rand_key();
    start_key(1, k);
    collect(1, k, 100, 1'b0, '0, 0);

    // key_valid held through RUN with another key: only taken after rk_last.
    k  = rand_key();
    k2 = rand_key();
    start_key(2, k);
    collect(2, k, 100, 1'b1, k2, 0);
    collect(2, k2, 60, 1'b0, '0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
